aib_lane_remap: RTL and testbench

//   Parametrised, registered successor to the fixed AIB IO mapping layer. Maps

---
 rtl/aib_lane_remap.sv | 137 +++++++++++++
 tb/tb_aib_lane_remap.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aib_lane_remap.sv
// aib_lane_remap: programmable tx/rx lane-to-pad mapping with checked, glitch-free shadow/active commit
module aib_lane_remap #(
  parameter int NUM_IO = 96,
  parameter int DATA_W = 20,
  parameter int GAP_TMO = 255,
  localparam int PAD_W = $clog2(NUM_IO),
  localparam int LANE_W = $clog2(DATA_W),
  localparam int CNT_W = $clog2(GAP_TMO + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_wr_vld,
  output logic              o_cfg_wr_rdy,
  input  logic              i_cfg_wr_dir,
  input  logic [LANE_W-1:0] i_cfg_wr_lane,
  input  logic [PAD_W-1:0]  i_cfg_wr_pad,
  input  logic              i_commit,
  output logic              o_commit_busy,
  output logic              o_commit_done,
  output logic              o_commit_err,
  output logic              o_map_err,
  input  logic              i_tx_vld,
  input  logic [DATA_W-1:0] i_tx_data0,
  input  logic [DATA_W-1:0] i_tx_data1,
  output logic [NUM_IO-1:0] o_iob_tx_data0,
  output logic [NUM_IO-1:0] o_iob_tx_data1,
  output logic [NUM_IO-1:0] o_iob_tx_en,
  input  logic [NUM_IO-1:0] i_iob_rx_data0,
  input  logic [NUM_IO-1:0] i_iob_rx_data1,
  output logic [DATA_W-1:0] o_rx_data0,
  output logic [DATA_W-1:0] o_rx_data1
);
  typedef enum logic [2:0] {IDLE, CHECK, WAIT_GAP, SWAP, ABORT} state_t;
  state_t state, state_nx;
  logic [PAD_W-1:0] shadow_tx [DATA_W];
  logic [PAD_W-1:0] shadow_rx [DATA_W];
  logic [PAD_W-1:0] active_tx [DATA_W];
  logic [PAD_W-1:0] active_rx [DATA_W];
  logic [LANE_W-1:0] scan_k;
  logic [CNT_W-1:0] gap_cnt;
  logic [PAD_W-1:0] cur_tx, cur_rx;
  logic [NUM_IO-1:0] tx0_nx, tx1_nx, en_nx;
  logic scan_err, hit, wr_fire, scan_last;
  assign wr_fire = i_cfg_wr_vld && o_cfg_wr_rdy && (int'(i_cfg_wr_lane) < DATA_W);
  assign scan_last = scan_k == LANE_W'(DATA_W - 1);
  // commit FSM state register
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_nx;
  // scan hits are held until the scan ends so commit latency never depends on where a collision sits
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = i_commit ? CHECK : IDLE;
      CHECK:    state_nx = scan_last ? WAIT_GAP : CHECK;
      WAIT_GAP: state_nx = scan_err ? ABORT : !i_tx_vld ? SWAP : gap_cnt == CNT_W'(GAP_TMO) ? ABORT : WAIT_GAP;
      SWAP:     state_nx = IDLE;
      ABORT:    state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end
  // commit status outputs decoded from state
  always_comb begin
    o_cfg_wr_rdy = state == IDLE;
    o_commit_busy = state != IDLE;
    o_commit_done = state == SWAP || state == ABORT;
    o_commit_err = state == ABORT;
  end
  // lane k of the shadow tables against lanes below it and against the pad range
  always_comb begin
    cur_tx = shadow_tx[scan_k];
    cur_rx = shadow_rx[scan_k];
    hit = ({1'b0, cur_tx} >= (PAD_W + 1)'(NUM_IO)) || ({1'b0, cur_rx} >= (PAD_W + 1)'(NUM_IO));
    for (int j = 0; j < DATA_W; j++)
      if (j < int'(scan_k) && (shadow_tx[j] == cur_tx || shadow_rx[j] == cur_rx)) hit = 1'b1;
  end
  // scan index, gap counter, scan error and sticky map error
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scan_k <= '0;
      gap_cnt <= '0;
      scan_err <= 1'b0;
      o_map_err <= 1'b0;
    end else begin
      scan_k <= state == CHECK ? scan_k + 1'b1 : '0;
      gap_cnt <= state == WAIT_GAP ? gap_cnt + 1'b1 : '0;
      scan_err <= state == IDLE ? 1'b0 : scan_err | (state == CHECK && hit);
      o_map_err <= state == SWAP ? 1'b0 : state == ABORT ? 1'b1 : o_map_err;
    end
  end
  // shadow writes and atomic shadow-to-active swap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DATA_W; i++) begin
        shadow_tx[i] <= PAD_W'(i);
        active_tx[i] <= PAD_W'(i);
        shadow_rx[i] <= PAD_W'(DATA_W + i);
        active_rx[i] <= PAD_W'(DATA_W + i);
      end
    end else begin
      if (wr_fire && i_cfg_wr_dir) shadow_rx[i_cfg_wr_lane] <= i_cfg_wr_pad;
      if (wr_fire && !i_cfg_wr_dir) shadow_tx[i_cfg_wr_lane] <= i_cfg_wr_pad;
      if (state == SWAP) begin
        active_tx <= shadow_tx;
        active_rx <= shadow_rx;
      end
    end
  end
  // scatter tx lanes onto their active pads
  always_comb begin
    tx0_nx = '0;
    tx1_nx = '0;
    en_nx = '0;
    for (int l = 0; l < DATA_W; l++) begin
      tx0_nx[active_tx[l]] = i_tx_data0[l];
      tx1_nx[active_tx[l]] = i_tx_data1[l];
      en_nx[active_tx[l]] = 1'b1;
    end
  end
  // registered tx pads and rx lanes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_iob_tx_data0 <= '0;
      o_iob_tx_data1 <= '0;
      o_iob_tx_en <= '0;
      o_rx_data0 <= '0;
      o_rx_data1 <= '0;
    end else begin
      o_iob_tx_data0 <= tx0_nx;
      o_iob_tx_data1 <= tx1_nx;
      o_iob_tx_en <= en_nx;
      for (int l = 0; l < DATA_W; l++) begin
        o_rx_data0[l] <= i_iob_rx_data0[active_rx[l]];
        o_rx_data1[l] <= i_iob_rx_data1[active_rx[l]];
      end
    end
  end
endmodule

// File: tb/tb_aib_lane_remap.sv
// tb_aib_lane_remap: randomized checks of aib_lane_remap against a table-level reference model
module tb_aib_lane_remap;
  localparam int NIO = 96;
  localparam int DW = 20;
  localparam int TMO = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_vld = 1'b0, wr_rdy, wr_dir = 1'b0;
  logic [4:0] wr_lane = '0;
  logic [6:0] wr_pad = '0;
  logic commit = 1'b0, busy, done, cerr, map_err;
  logic tx_vld = 1'b0;
  logic [DW-1:0] tx_d0 = '0, tx_d1 = '0, rx_o0, rx_o1;
  logic [NIO-1:0] pad_o0, pad_o1, pad_en, rx_p0 = '0, rx_p1 = '0;
  int errors = 0;
  int checks = 0;
  int sh_tx [DW];
  int sh_rx [DW];
  int act_tx [DW];
  int act_rx [DW];
  bit seen;

  aib_lane_remap dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_wr_vld(wr_vld), .o_cfg_wr_rdy(wr_rdy), .i_cfg_wr_dir(wr_dir),
    .i_cfg_wr_lane(wr_lane), .i_cfg_wr_pad(wr_pad),
    .i_commit(commit), .o_commit_busy(busy), .o_commit_done(done),
    .o_commit_err(cerr), .o_map_err(map_err),
    .i_tx_vld(tx_vld), .i_tx_data0(tx_d0), .i_tx_data1(tx_d1),
    .o_iob_tx_data0(pad_o0), .o_iob_tx_data1(pad_o1), .o_iob_tx_en(pad_en),
    .i_iob_rx_data0(rx_p0), .i_iob_rx_data1(rx_p1),
    .o_rx_data0(rx_o0), .o_rx_data1(rx_o1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void defaults();
    for (int i = 0; i < DW; i++) begin
      sh_tx[i] = i;
      act_tx[i] = i;
      sh_rx[i] = DW + i;
      act_rx[i] = DW + i;
    end
  endfunction

  function automatic void set_sh(input bit dir, input int lane, input int pad);
    if (dir) sh_rx[lane] = pad;
    else sh_tx[lane] = pad;
  endfunction

  function automatic bit legal();
    bit used_tx [128];
    bit used_rx [128];
    for (int i = 0; i < DW; i++) begin
      if (sh_tx[i] >= NIO || used_tx[sh_tx[i]]) return 1'b0;
      if (sh_rx[i] >= NIO || used_rx[sh_rx[i]]) return 1'b0;
      used_tx[sh_tx[i]] = 1'b1;
      used_rx[sh_rx[i]] = 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic [NIO-1:0] pad_tx(input logic [DW-1:0] d, input bit en);
    logic [NIO-1:0] r = '0;
    for (int p = 0; p < NIO; p++)
      for (int l = 0; l < DW; l++)
        if (act_tx[l] == p) r[p] = en ? 1'b1 : d[l];
    return r;
  endfunction

  function automatic logic [DW-1:0] lane_rx(input logic [NIO-1:0] pads);
    logic [DW-1:0] r;
    for (int l = 0; l < DW; l++) r[l] = pads[act_rx[l]];
    return r;
  endfunction

  task automatic wr(input bit dir, input int lane, input int pad);
    wr_vld = 1'b1;
    wr_dir = dir;
    wr_lane = 5'(lane);
    wr_pad = 7'(pad);
    check("wr_rdy", wr_rdy, 1);
    tick();
    wr_vld = 1'b0;
    set_sh(dir, lane, pad);
  endtask

  task automatic dp_check(input int n);
    logic [DW-1:0] t0, t1;
    logic [NIO-1:0] r0, r1;
    for (int k = 0; k < n; k++) begin
      t0 = DW'($urandom);
      t1 = DW'($urandom);
      r0 = {$urandom, $urandom, $urandom};
      r1 = {$urandom, $urandom, $urandom};
      tx_d0 = t0;
      tx_d1 = t1;
      rx_p0 = r0;
      rx_p1 = r1;
      tx_vld = 1'($urandom);
      tick();
      check("tx_pad0", pad_o0, pad_tx(t0, 0));
      check("tx_pad1", pad_o1, pad_tx(t1, 0));
      check("tx_en", pad_en, pad_tx(t0, 1));
      check("rx_lane0", rx_o0, lane_rx(r0));
      check("rx_lane1", rx_o1, lane_rx(r1));
    end
    tx_vld = 1'b0;
  endtask

  task automatic do_commit(input int hold, input bit same_wr, input bit wdir, input int wlane, input int wpad, input bit mid_wr);
    int lat, exp_lat;
    bit bad, exp_err, got_err;
    if (same_wr) begin
      wr_vld = 1'b1;
      wr_dir = wdir;
      wr_lane = 5'(wlane);
      wr_pad = 7'(wpad);
      set_sh(wdir, wlane, wpad);
    end
    bad = !legal();
    exp_err = bad || hold > TMO;
    exp_lat = bad ? DW + 2 : DW + 2 + (hold > TMO ? TMO : hold);
    lat = -1;
    got_err = 1'b0;
    commit = 1'b1;
    tx_vld = 1'b1;
    for (int n = 1; n <= 400 && lat < 0; n++) begin
      tick();
      commit = 1'b0;
      wr_vld = 1'b0;
      if (mid_wr && n == 5) begin
        wr_vld = 1'b1;
        wr_dir = 1'b0;
        wr_lane = 5'd1;
        wr_pad = 7'd90;
        check("rdy_busy", wr_rdy, 0);
      end
      tx_vld = n < DW + 1 + hold;
      if (done) begin
        lat = n;
        got_err = cerr;
      end
    end
    wr_vld = 1'b0;
    tx_vld = 1'b0;
    check("commit_lat", 32'(lat), 32'(exp_lat));
    check("commit_err", got_err, exp_err);
    tick();
    check("done_pulse", done, 0);
    check("idle_after", busy, 0);
    check("map_err", map_err, exp_err);
    if (!exp_err) begin
      act_tx = sh_tx;
      act_rx = sh_rx;
    end
  endtask

  initial begin
    defaults();
    repeat (3) tick();
    rst = 1'b0;
    check("rst_rdy", wr_rdy, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", cerr, 0);
    check("rst_map_err", map_err, 0);
    check("rst_tx_en", pad_en, 0);
    check("rst_rx", rx_o0, 0);
    tx_d0 = 20'hA5A5A;
    tx_vld = 1'b1;
    rx_p0 = {$urandom, $urandom, $urandom};
    tick();
    check("a5_pads", pad_o0[19:0], 20'hA5A5A);
    check("a5_en", pad_en, {76'b0, {20{1'b1}}});
    check("a5_rx", rx_o0, rx_p0[39:20]);
    dp_check(6);
    wr(0, 0, 95);
    do_commit(0, 0, 0, 0, 0, 0);
    tick();
    check("pad95_en", pad_en[95], 1);
    check("pad0_en", pad_en[0], 0);
    dp_check(4);
    wr(0, 3, 50);
    wr(0, 7, 50);
    do_commit(0, 0, 0, 0, 0, 0);
    dp_check(3);
    wr(0, 7, 51);
    do_commit(1000, 0, 0, 0, 0, 0);
    commit = 1'b1;
    tx_vld = 1'b1;
    seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      commit = 1'b0;
      rst = n == 35;
      if (n == 34) check("pre_rst_busy", busy, 1);
      if (n == 36) begin
        check("post_rst_rdy", wr_rdy, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_map_err", map_err, 0);
      end
      if (done) seen = 1'b1;
    end
    check("rst_no_done", seen, 0);
    defaults();
    dp_check(4);
    do_commit(10, 0, 0, 0, 0, 0);
    do_commit(0, 0, 0, 0, 0, 1);
    dp_check(3);
    do_commit(2, 1, 0, 4, 21, 0);
    dp_check(3);
    wr(1, 2, 100);
    do_commit(0, 0, 0, 0, 0, 0);
    wr(1, 2, DW + 2);
    do_commit(0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 3; k++) begin
        bit dir;
        int a, b, pa, pb;
        dir = 1'($urandom);
        a = $urandom_range(0, DW - 1);
        b = $urandom_range(0, DW - 1);
        pa = dir ? sh_rx[a] : sh_tx[a];
        pb = dir ? sh_rx[b] : sh_tx[b];
        wr(dir, a, pb);
        wr(dir, b, pa);
      end
      if ($urandom_range(0, 3) == 0) wr(1'($urandom), $urandom_range(0, DW - 1), $urandom_range(0, 127));
      do_commit($urandom_range(0, 4), 0, 0, 0, 0, 0);
      dp_check(2);
      if (map_err) begin
        for (int i = 0; i < DW; i++) begin
          wr(0, i, act_tx[i]);
          wr(1, i, act_rx[i]);
        end
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
